// File: rtl/cp0_unit_pkg.sv
// rtl/cp0_unit_pkg.sv - shared CP0 register indices, exception codes and helpers
//
// Purpose : constants shared by cp0_unit and the pipeline exception logic.
// Contents: CP0 register numbers, ExcCode values, EPC computation helper.
package cp0_unit_pkg;

   localparam logic [4:0] CP0_REG_SR    = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
   localparam logic [4:0] CP0_REG_EPC   = 5'd14;
   localparam logic [4:0] CP0_REG_PRID  = 5'd15;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   // A delay-slot instruction restarts at its branch, one word earlier.
   function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
      logic [31:0] raw;
      raw = bd ? (pc - 32'd4) : pc;
      return {raw[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// rtl/cp0_unit_if.sv - pipeline <-> CP0 signal bundle
//
// Purpose : groups the M-stage request signals and CP0 responses.
// master  : pipeline side (drives A1..EXLClr, receives Dout/EPCOut/Req).
// slave   : cp0_unit side.
interface cp0_unit_if;

   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] Din;
   logic        WE;
   logic [31:0] PC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic [31:0] Dout;
   logic [31:0] EPCOut;
   logic        Req;

   modport master (
      output A1, A2, Din, WE, PC, BDIn, ExcCodeIn, HWInt, EXLClr,
      input  Dout, EPCOut, Req
   );

   modport slave (
      input  A1, A2, Din, WE, PC, BDIn, ExcCodeIn, HWInt, EXLClr,
      output Dout, EPCOut, Req
   );

endinterface

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - MIPS-style coprocessor 0: SR, Cause, EPC, PrID
//
// Purpose : holds exception state, raises Req for interrupts/exceptions,
//           services mtc0/mfc0 and eret.
// Ports   : clk    - clock, rising edge
//           reset  - asynchronous active-low reset
//           bus    - cp0_unit_if.slave (A1/A2/Din/WE/PC/BDIn/ExcCodeIn/
//                    HWInt/EXLClr in; Dout/EPCOut/Req out)
// Param   : PRID   - value read back from register 15
module cp0_unit
   import cp0_unit_pkg::*;
#(
   parameter logic [31:0] PRID = 32'h2020_0007
) (
   input  logic       clk,
   input  logic       reset,
   cp0_unit_if.slave  bus
);

   logic [5:0]  im_q,       im_d;
   logic        exl_q,      exl_d;
   logic        ie_q,       ie_d;
   logic        bd_q,       bd_d;
   logic [5:0]  ip_q,       ip_d;
   logic [4:0]  exc_code_q, exc_code_d;
   logic [31:0] epc_q,      epc_d;

   logic int_req;
   logic exc_req;
   logic req;

   // EXL masks both sources so a handler is never re-entered.
   assign int_req = ie_q & ~exl_q & (|(bus.HWInt & im_q));
   assign exc_req = ~exl_q & (bus.ExcCodeIn != EXC_INT);
   assign req     = int_req | exc_req;

   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      ip_d       = bus.HWInt;

      if (req) begin
         // Exception entry overrides any mtc0 or eret in the same cycle.
         exl_d      = 1'b1;
         bd_d       = bus.BDIn;
         exc_code_d = int_req ? EXC_INT : bus.ExcCodeIn;
         epc_d      = epc_of(bus.PC, bus.BDIn);
      end else begin
         if (bus.WE) begin
            if (bus.A2 == CP0_REG_SR) begin
               im_d  = bus.Din[15:10];
               exl_d = bus.Din[1];
               ie_d  = bus.Din[0];
            end else if (bus.A2 == CP0_REG_EPC) begin
               epc_d = {bus.Din[31:2], 2'b00};
            end
         end
         if (bus.EXLClr) begin
            exl_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ip_q       <= '0;
         exc_code_q <= '0;
         epc_q      <= '0;
      end else begin
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ip_q       <= ip_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
      end
   end

   always_comb begin
      bus.Dout = '0;
      case (bus.A1)
         CP0_REG_SR:    bus.Dout = {16'b0, im_q, 8'b0, exl_q, ie_q};
         CP0_REG_CAUSE: bus.Dout = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
         CP0_REG_EPC:   bus.Dout = epc_q;
         CP0_REG_PRID:  bus.Dout = PRID;
         default:       bus.Dout = '0;
      endcase
   end

   assign bus.EPCOut = epc_q;
   assign bus.Req    = req;

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - directed vector bench for cp0_unit
module tb_cp0_unit;

   localparam logic [31:0] PRID_VAL = 32'h2020_0007;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   cp0_unit_if bus ();

   cp0_unit #(.PRID(PRID_VAL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  a2;
      logic [31:0] din;
      logic [31:0] pc;
      logic        bd;
      logic [4:0]  exc;
      logic [5:0]  hw;
      logic        clr;
      logic        exp_req;
      logic [4:0]  rd;
      logic [31:0] exp_rd;
      logic [31:0] exp_epc;
   } vec_t;

   vec_t vecs[21];

   function automatic vec_t mk(input logic we, input logic [4:0] a2, input logic [31:0] din,
                               input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                               input logic [5:0] hw, input logic clr, input logic exp_req,
                               input logic [4:0] rd, input logic [31:0] exp_rd,
                               input logic [31:0] exp_epc);
      vec_t v;
      v.we = we; v.a2 = a2; v.din = din; v.pc = pc; v.bd = bd; v.exc = exc;
      v.hw = hw; v.clr = clr; v.exp_req = exp_req; v.rd = rd; v.exp_rd = exp_rd;
      v.exp_epc = exp_epc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.A1 = 5'd0; bus.A2 = 5'd0; bus.Din = '0; bus.WE = 1'b0; bus.PC = '0;
      bus.BDIn = 1'b0; bus.ExcCodeIn = 5'd0; bus.HWInt = 6'd0; bus.EXLClr = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;
      drive_idle();

      //         we  a2  din            pc             bd exc  hw       clr req rd   exp_rd         exp_epc
      vecs[0]  = mk(1, 12, 32'h0000_0401, 32'h0,         0, 0,  6'b000000, 0, 0, 12, 32'h0000_0401, 32'h0);
      vecs[1]  = mk(0, 0,  32'h0,         32'h0000_3010, 0, 0,  6'b000001, 0, 1, 12, 32'h0000_0403, 32'h0000_3010);
      vecs[2]  = mk(0, 0,  32'h0,         32'h0000_3050, 0, 10, 6'b000001, 0, 0, 13, 32'h0000_0400, 32'h0000_3010);
      vecs[3]  = mk(0, 0,  32'h0,         32'h0,         0, 0,  6'b000100, 0, 0, 13, 32'h0000_1000, 32'h0000_3010);
      vecs[4]  = mk(0, 0,  32'h0,         32'h0,         0, 0,  6'b000001, 1, 0, 12, 32'h0000_0401, 32'h0000_3010);
      vecs[5]  = mk(0, 0,  32'h0,         32'h0000_3040, 0, 0,  6'b000001, 0, 1, 14, 32'h0000_3040, 32'h0000_3040);
      vecs[6]  = mk(0, 0,  32'h0,         32'h0,         0, 0,  6'b000000, 1, 0, 12, 32'h0000_0401, 32'h0000_3040);
      vecs[7]  = mk(0, 0,  32'h0,         32'h0000_3024, 1, 12, 6'b000000, 0, 1, 13, 32'h8000_0030, 32'h0000_3020);
      vecs[8]  = mk(0, 0,  32'h0,         32'h0,         0, 0,  6'b000000, 1, 0, 12, 32'h0000_0401, 32'h0000_3020);
      vecs[9]  = mk(1, 14, 32'h1234_5678, 32'h0000_3000, 0, 4,  6'b000000, 0, 1, 14, 32'h0000_3000, 32'h0000_3000);
      vecs[10] = mk(0, 0,  32'h0,         32'h0,         0, 0,  6'b000000, 1, 0, 13, 32'h0000_0010, 32'h0000_3000);
      vecs[11] = mk(1, 14, 32'h1234_5678, 32'h0,         0, 0,  6'b000000, 0, 0, 14, 32'h1234_5678, 32'h1234_5678);
      vecs[12] = mk(1, 14, 32'h8765_4323, 32'h0,         0, 0,  6'b000000, 0, 0, 14, 32'h8765_4320, 32'h8765_4320);
      vecs[13] = mk(1, 13, 32'hFFFF_FFFF, 32'h0,         0, 0,  6'b000000, 0, 0, 13, 32'h0000_0010, 32'h8765_4320);
      vecs[14] = mk(1, 15, 32'h0,         32'h0,         0, 0,  6'b000000, 0, 0, 15, PRID_VAL,      32'h8765_4320);
      vecs[15] = mk(1, 12, 32'hFFFF_08FD, 32'h0,         0, 0,  6'b000000, 0, 0, 12, 32'h0000_0801, 32'h8765_4320);
      vecs[16] = mk(0, 0,  32'h0,         32'h0000_3100, 0, 5,  6'b000010, 0, 1, 13, 32'h0000_0800, 32'h0000_3100);
      vecs[17] = mk(0, 0,  32'h0,         32'h0,         0, 0,  6'b000000, 0, 0, 7,  32'h0000_0000, 32'h0000_3100);
      vecs[18] = mk(0, 0,  32'h0,         32'h0000_3200, 0, 12, 6'b000000, 1, 0, 12, 32'h0000_0801, 32'h0000_3100);
      vecs[19] = mk(0, 0,  32'h0,         32'h0000_3204, 0, 10, 6'b000000, 1, 1, 12, 32'h0000_0803, 32'h0000_3204);
      vecs[20] = mk(1, 12, 32'h0,         32'h0,         0, 0,  6'b000000, 0, 0, 12, 32'h0000_0000, 32'h0000_3204);

      // Reset state, checked while reset is still held.
      repeat (2) @(posedge clk);
      #1;
      check("rst_req", {31'b0, bus.Req}, 32'h0);
      check("rst_epcout", bus.EPCOut, 32'h0);
      bus.A1 = 5'd12; #1; check("rst_sr", bus.Dout, 32'h0);
      bus.A1 = 5'd13; #1; check("rst_cause", bus.Dout, 32'h0);
      bus.A1 = 5'd14; #1; check("rst_epc", bus.Dout, 32'h0);
      bus.A1 = 5'd15; #1; check("rst_prid", bus.Dout, PRID_VAL);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         bus.WE = vecs[i].we; bus.A2 = vecs[i].a2; bus.Din = vecs[i].din;
         bus.PC = vecs[i].pc; bus.BDIn = vecs[i].bd; bus.ExcCodeIn = vecs[i].exc;
         bus.HWInt = vecs[i].hw; bus.EXLClr = vecs[i].clr; bus.A1 = vecs[i].rd;
         #1;
         check($sformatf("v%0d_req", i), {31'b0, bus.Req}, {31'b0, vecs[i].exp_req});
         @(posedge clk);
         #1;
         check($sformatf("v%0d_dout", i), bus.Dout, vecs[i].exp_rd);
         check($sformatf("v%0d_epcout", i), bus.EPCOut, vecs[i].exp_epc);
      end

      // Enter a handler, then pulse reset between clock edges.
      @(negedge clk);
      drive_idle();
      bus.ExcCodeIn = 5'd4; bus.PC = 32'h0000_3300; bus.HWInt = 6'b000001;
      #1;
      check("mid_req", {31'b0, bus.Req}, 32'h1);
      @(posedge clk);
      #1;
      bus.ExcCodeIn = 5'd0;
      bus.A1 = 5'd12; #1;
      check("mid_sr_exl", bus.Dout, 32'h0000_0002);
      check("mid_epc", bus.EPCOut, 32'h0000_3300);
      reset = 1'b0;
      #1;
      check("async_epc", bus.EPCOut, 32'h0);
      check("async_sr", bus.Dout, 32'h0);
      bus.A1 = 5'd13; #1;
      check("async_cause", bus.Dout, 32'h0);
      check("async_req", {31'b0, bus.Req}, 32'h0);
      reset = 1'b1;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 Parameter: PRID, default 32'h2020_0007, value returned on reads of register 15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserted while 0.
REQ-004 A1  input  5  read register number (mfc0).
REQ-005 A2  input  5  write register number (mtc0).
REQ-006 Din  input  32  write data.
REQ-007 WE  input  1  mtc0 write enable.
REQ-008 PC  input  32  PC of instruction in M stage.
REQ-009 BDIn  input  1  M-stage instruction sits in a branch delay slot.
REQ-010 ExcCodeIn  input  5  synchronous exception code of M-stage instruction; 0 = none.
REQ-011 HWInt  input  6  device interrupt lines (bit 0 = timer 0 IRQ, bit 1 = timer 1 IRQ, bit 2 = external).
REQ-012 EXLClr  input  1  eret in M stage.
REQ-013 Dout  output  32  read data for A1.
REQ-014 EPCOut  output  32  current EPC register.
REQ-015 Req  output  1  exception/interrupt taken this cycle; flush pipeline, redirect fetch to handler.

Function
REQ-016 Registers: SR(12) = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}; Cause(13) = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}; EPC(14) = 32 bits; PrID(15) = PRID constant.
REQ-017 Dout is combinational on A1; registers other than 12-15 read as 0; unimplemented SR/Cause bits read 0.
REQ-018 IntReq = IE & ~EXL & |(HWInt & IM); ExcReq = ~EXL & (ExcCodeIn != 0); Req = IntReq | ExcReq, combinational.
REQ-019 Interrupt has priority: if IntReq and ExcReq are both 1, the captured ExcCode is 0.
REQ-020 On Req at an edge: EXL <= 1; BD <= BDIn; ExcCode <= IntReq ? 0 : ExcCodeIn; EPC <= (BDIn ? PC-4 : PC) with bits [1:0] forced to 00.
REQ-021 IP[15:10] <= HWInt every cycle, regardless of Req, WE, or EXL; IP is not software-writable.
REQ-022 mtc0 (WE=1, no Req): A2=12 writes IM, EXL and IE from Din; A2=14 writes EPC = {Din[31:2], 2'b00}; writes to 13 and 15 are ignored.
REQ-023 Req and WE in the same cycle: the exception update wins and the mtc0 write is dropped.
REQ-024 EXLClr=1 with no Req: EXL <= 0 at the edge. If EXLClr and Req are both 1, the REQ-020 update wins.
REQ-025 While EXL=1, Req stays 0 regardless of HWInt or ExcCodeIn; pending HWInt still appears in IP.
REQ-026 EPCOut is the registered EPC with no write bypass; the pipeline stalls eret behind an in-flight mtc0 to EPC.
REQ-027 Exception capture needs only one cycle; Req has zero-cycle latency from its inputs.

Reset
REQ-028 While reset=0, asynchronously: IM=0, EXL=0, IE=0, BD=0, IP=0, ExcCode=0, EPC=0.
REQ-029 During and after reset, Req=0 until inputs satisfy REQ-018; Dout follows A1 over the reset values.
REQ-030 Reset asserted mid-handler (EXL=1) returns EXL to 0; the EPC value is lost.

Structure
REQ-031 A shared package holds register indices (SR=12, CAUSE=13, EPC=14, PRID=15) and ExcCode constants (INT=0, ADEL=4, ADES=5, RI=10, OV=12); the pipeline exception logic uses the same package.
REQ-032 No sub-module is required; the priority/request logic stays inline in cp0_unit.

Verification
REQ-033 Reset, then SR write Din=32'h0000_0401 (IM[10]=1, IE=1), then HWInt=6'b000001 with PC=32'h0000_3010 -> Req=1 that cycle; next cycle EXL=1, ExcCode=0, EPC=32'h0000_3010, IP[10]=1.
REQ-034 EXL=0, ExcCodeIn=12, BDIn=1, PC=32'h0000_3024 -> Req=1; then Cause ExcCode=12, BD=1, EPC=32'h0000_3020.
REQ-035 With EXL=1, assert HWInt and ExcCodeIn=10 -> Req=0 and IP tracks HWInt; then EXLClr=1 -> EXL=0, and next cycle Req=1 if the interrupt is still pending and enabled.
REQ-036 Same cycle: WE=1, A2=14, Din=32'h1234_5678, and ExcCodeIn=4 with PC=32'h0000_3000 -> EPC=32'h0000_3000 (mtc0 dropped); an mtc0 with no exception -> EPC=32'h1234_5678.
REQ-037 HWInt=6'b000010 with IM[11]=1 together with ExcCodeIn=5 -> ExcCode=0; reading A1=15 -> Dout=PRID; reading A1=7 -> Dout=0.
REQ-038 Pulse reset low between edges while EXL=1 -> all registers cleared immediately without waiting for clk.
